execution_muldiv: RTL and testbench

EXECUTION_MULDIV -- requirements
Module: execution_muldiv

---
 rtl/execution_muldiv_if.sv | 55 +++++
 rtl/execution_muldiv.sv | 224 ++++++++++++++++++++++
 tb/tb_execution_muldiv.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/execution_muldiv_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// Upstream drives the master modport; the execute stage uses the slave modport.
interface execution_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_in;
    logic            ready_out;
    logic            Ctl_ALUSrc_in;
    logic            Ctl_MemtoReg_in;
    logic            Ctl_RegWrite_in;
    logic            Ctl_MemRead_in;
    logic            Ctl_MemWrite_in;
    logic            Ctl_Branch_in;
    logic            Ctl_ALUOpcode1_in;
    logic            Ctl_ALUOpcode0_in;
    logic [6:0]      funct7_in;
    logic [2:0]      funct3_in;
    logic [4:0]      Rd_in;
    logic [XLEN-1:0] Immediate_in;
    logic [XLEN-1:0] ReadData1_in;
    logic [XLEN-1:0] ReadData2_in;
    logic [XLEN-1:0] PC_in;

    logic            valid_out;
    logic            Ctl_MemtoReg_out;
    logic            Ctl_RegWrite_out;
    logic            Ctl_MemRead_out;
    logic            Ctl_MemWrite_out;
    logic            Ctl_Branch_out;
    logic [4:0]      Rd_out;
    logic [XLEN-1:0] ALUresult_out;
    logic [XLEN-1:0] PCimm_out;
    logic [XLEN-1:0] ReadData2_out;
    logic            Zero_out;
    logic            BranchTaken_out;
    logic            stall_out;

    modport master (
        output valid_in, Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in,
               Ctl_MemWrite_in, Ctl_Branch_in, Ctl_ALUOpcode1_in, Ctl_ALUOpcode0_in,
               funct7_in, funct3_in, Rd_in, Immediate_in, ReadData1_in, ReadData2_in, PC_in,
        input  ready_out, valid_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
               Ctl_MemWrite_out, Ctl_Branch_out, Rd_out, ALUresult_out, PCimm_out,
               ReadData2_out, Zero_out, BranchTaken_out, stall_out
    );

    modport slave (
        input  valid_in, Ctl_ALUSrc_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in,
               Ctl_MemWrite_in, Ctl_Branch_in, Ctl_ALUOpcode1_in, Ctl_ALUOpcode0_in,
               funct7_in, funct3_in, Rd_in, Immediate_in, ReadData1_in, ReadData2_in, PC_in,
        output ready_out, valid_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
               Ctl_MemWrite_out, Ctl_Branch_out, Rd_out, ALUresult_out, PCimm_out,
               ReadData2_out, Zero_out, BranchTaken_out, stall_out
    );
endinterface

// File: rtl/execution_muldiv.sv
// Execute stage: single-cycle RV ALU/branch unit plus an iterative M-extension unit
// (one bit per cycle shift-add multiply / restoring divide on operand magnitudes).
module execution_muldiv #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MULDIV_EN = 1
) (
    input logic               clk,
    input logic               rst,
    execution_muldiv_if.slave ex_io
);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam bit          MdEn = (MULDIV_EN != 0);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // {a is signed, b is signed} for each M-op funct3
    function automatic logic [1:0] md_signs(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b100, 3'b110: md_signs = 2'b11;
            3'b010:                         md_signs = 2'b10;
            default:                        md_signs = 2'b00;
        endcase
    endfunction

    state_e              state_q;
    logic [ShW-1:0]      cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mag_q, a_q, b_q, pcimm_lat_q, rd2_lat_q;
    logic [2:0]          f3_q;
    logic [4:0]          ctl_lat_q, rd_lat_q;

    logic                valid_q, memtoreg_q, regwrite_q, memread_q, memwrite_q, branch_q;
    logic                zero_q, br_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     alu_q, pcimm_q, rd2_q;

    logic [1:0]          alu_op;
    logic [XLEN-1:0]     op_a, op_b, alu_res, pcimm;
    logic [ShW-1:0]      shamt;
    logic                br_taken, is_m_op;

    always_comb begin
        alu_op   = {ex_io.Ctl_ALUOpcode1_in, ex_io.Ctl_ALUOpcode0_in};
        op_a     = ex_io.ReadData1_in;
        op_b     = ex_io.Ctl_ALUSrc_in ? ex_io.Immediate_in : ex_io.ReadData2_in;
        pcimm    = ex_io.PC_in + ex_io.Immediate_in;
        shamt    = op_b[ShW-1:0];
        is_m_op  = (alu_op == 2'b10) && (ex_io.funct7_in == 7'b0000001);
        alu_res  = op_a + op_b;
        br_taken = 1'b0;
        unique case (alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: begin
                alu_res = op_a - op_b;
                case (ex_io.funct3_in)
                    3'b000:  br_taken = (op_a == op_b);
                    3'b001:  br_taken = (op_a != op_b);
                    3'b100:  br_taken = ($signed(op_a) < $signed(op_b));
                    3'b101:  br_taken = ($signed(op_a) >= $signed(op_b));
                    3'b110:  br_taken = (op_a < op_b);
                    3'b111:  br_taken = (op_a >= op_b);
                    default: br_taken = 1'b0;
                endcase
            end
            default: begin
                case (ex_io.funct3_in)
                    // I-type never subtracts: funct7 bits are immediate bits there
                    3'b000: alu_res = (alu_op == 2'b10 && ex_io.funct7_in[5]) ? op_a - op_b
                                                                              : op_a + op_b;
                    3'b001: alu_res = op_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b100: alu_res = op_a ^ op_b;
                    3'b101: alu_res = ex_io.funct7_in[5] ? XLEN'($signed(op_a) >>> shamt)
                                                         : op_a >> shamt;
                    3'b110: alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
        endcase
    end

    // Operand magnitudes at acceptance
    logic [1:0]      sgn_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;

    always_comb begin
        sgn_in   = md_signs(ex_io.funct3_in);
        mag_a_in = (sgn_in[1] && op_a[XLEN-1]) ? -op_a : op_a;
        mag_b_in = (sgn_in[0] && op_b[XLEN-1]) ? -op_b : op_b;
    end

    // One iteration; acc holds {hi, lo} for multiply and {rem, quo} for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   mul_addend;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_d;

    always_comb begin
        mul_addend = acc_q[0] ? mag_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        div_shift  = acc_q[2*XLEN-1:XLEN-1];
        div_diff   = div_shift - {1'b0, mag_q};
        div_ge     = (div_shift >= {1'b0, mag_q});
        if (f3_q[2]) begin
            acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and special cases, used in StDone
    logic [1:0]        sgn_q;
    logic              a_neg, b_neg, b_zero;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, md_res;

    always_comb begin
        sgn_q  = md_signs(f3_q);
        a_neg  = sgn_q[1] & a_q[XLEN-1];
        b_neg  = sgn_q[0] & b_q[XLEN-1];
        b_zero = (b_q == '0);
        prod_s = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quo_s  = (a_neg ^ b_neg) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = a_neg ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 md_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_res = b_zero ? '1 : quo_s;
            default:                md_res = b_zero ? a_q : rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            zero_q     <= 1'b0;
            br_q       <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            pcimm_q    <= '0;
            rd2_q      <= '0;
        end else begin
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            br_q       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ex_io.valid_in && is_m_op && MdEn) begin
                        state_q     <= StBusy;
                        cnt_q       <= '0;
                        f3_q        <= ex_io.funct3_in;
                        a_q         <= op_a;
                        b_q         <= op_b;
                        mag_q       <= ex_io.funct3_in[2] ? mag_b_in : mag_a_in;
                        acc_q       <= {{XLEN{1'b0}},
                                        (ex_io.funct3_in[2] ? mag_a_in : mag_b_in)};
                        ctl_lat_q   <= {ex_io.Ctl_MemtoReg_in, ex_io.Ctl_RegWrite_in,
                                        ex_io.Ctl_MemRead_in, ex_io.Ctl_MemWrite_in,
                                        ex_io.Ctl_Branch_in};
                        rd_lat_q    <= ex_io.Rd_in;
                        pcimm_lat_q <= pcimm;
                        rd2_lat_q   <= ex_io.ReadData2_in;
                    end else if (ex_io.valid_in) begin
                        valid_q    <= 1'b1;
                        memtoreg_q <= ex_io.Ctl_MemtoReg_in;
                        regwrite_q <= ex_io.Ctl_RegWrite_in & ~is_m_op;
                        memread_q  <= ex_io.Ctl_MemRead_in;
                        memwrite_q <= ex_io.Ctl_MemWrite_in;
                        branch_q   <= ex_io.Ctl_Branch_in;
                        br_q       <= br_taken;
                        alu_q      <= is_m_op ? '0 : alu_res;
                        zero_q     <= is_m_op ? 1'b1 : (alu_res == '0);
                        rd_q       <= ex_io.Rd_in;
                        pcimm_q    <= pcimm;
                        rd2_q      <= ex_io.ReadData2_in;
                    end
                end
                StBusy: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ShW'(XLEN - 1)) state_q <= StDone;
                end
                StDone: begin
                    state_q    <= StIdle;
                    valid_q    <= 1'b1;
                    {memtoreg_q, regwrite_q, memread_q, memwrite_q, branch_q} <= ctl_lat_q;
                    alu_q      <= md_res;
                    zero_q     <= (md_res == '0);
                    rd_q       <= rd_lat_q;
                    pcimm_q    <= pcimm_lat_q;
                    rd2_q      <= rd2_lat_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ex_io.ready_out        = (state_q == StIdle);
    assign ex_io.stall_out        = (state_q != StIdle);
    assign ex_io.valid_out        = valid_q;
    assign ex_io.Ctl_MemtoReg_out = memtoreg_q;
    assign ex_io.Ctl_RegWrite_out = regwrite_q;
    assign ex_io.Ctl_MemRead_out  = memread_q;
    assign ex_io.Ctl_MemWrite_out = memwrite_q;
    assign ex_io.Ctl_Branch_out   = branch_q;
    assign ex_io.Rd_out           = rd_q;
    assign ex_io.ALUresult_out    = alu_q;
    assign ex_io.PCimm_out        = pcimm_q;
    assign ex_io.ReadData2_out    = rd2_q;
    assign ex_io.Zero_out         = zero_q;
    assign ex_io.BranchTaken_out  = br_q;
endmodule

// File: tb/tb_execution_muldiv.sv
// Directed, table-driven bench for execution_muldiv (XLEN=32), plus reset-abort
// and MULDIV_EN=0 sequences.
module tb_execution_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execution_muldiv_if #(.XLEN(32)) bus ();
    execution_muldiv_if #(.XLEN(32)) bus_n ();

    execution_muldiv #(.XLEN(32), .MULDIV_EN(1)) dut (.clk(clk), .rst(rst), .ex_io(bus));
    execution_muldiv #(.XLEN(32), .MULDIV_EN(0)) dut_n (.clk(clk), .rst(rst), .ex_io(bus_n));

    typedef struct {
        logic        alusrc;
        logic [1:0]  aluop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a, b, imm, pc;
        logic [31:0] exp_res;
        logic        exp_br;
        logic        md;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic alusrc, input logic [1:0] aluop, input logic [6:0] f7,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [31:0] exp_res, input logic exp_br, input logic md);
        vec_t r;
        r.alusrc = alusrc; r.aluop = aluop; r.f7 = f7; r.f3 = f3;
        r.a = a; r.b = b; r.imm = imm; r.pc = pc;
        r.exp_res = exp_res; r.exp_br = exp_br; r.md = md;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.valid_in = 0; bus.Ctl_ALUSrc_in = 0; bus.Ctl_MemtoReg_in = 0;
        bus.Ctl_RegWrite_in = 0; bus.Ctl_MemRead_in = 0; bus.Ctl_MemWrite_in = 0;
        bus.Ctl_Branch_in = 0; bus.Ctl_ALUOpcode1_in = 0; bus.Ctl_ALUOpcode0_in = 0;
        bus.funct7_in = 0; bus.funct3_in = 0; bus.Rd_in = 0; bus.Immediate_in = 0;
        bus.ReadData1_in = 0; bus.ReadData2_in = 0; bus.PC_in = 0;
        bus_n.valid_in = 0; bus_n.Ctl_ALUSrc_in = 0; bus_n.Ctl_MemtoReg_in = 0;
        bus_n.Ctl_RegWrite_in = 0; bus_n.Ctl_MemRead_in = 0; bus_n.Ctl_MemWrite_in = 0;
        bus_n.Ctl_Branch_in = 0; bus_n.Ctl_ALUOpcode1_in = 0; bus_n.Ctl_ALUOpcode0_in = 0;
        bus_n.funct7_in = 0; bus_n.funct3_in = 0; bus_n.Rd_in = 0; bus_n.Immediate_in = 0;
        bus_n.ReadData1_in = 0; bus_n.ReadData2_in = 0; bus_n.PC_in = 0;
    endtask

    task automatic set_inputs(input vec_t v, input logic [4:0] rd);
        bus.Ctl_ALUSrc_in = v.alusrc;
        bus.Ctl_ALUOpcode1_in = v.aluop[1];
        bus.Ctl_ALUOpcode0_in = v.aluop[0];
        bus.Ctl_MemtoReg_in = (v.aluop == 2'b00);
        bus.Ctl_RegWrite_in = 1'b1;
        bus.Ctl_MemRead_in = 1'b0;
        bus.Ctl_MemWrite_in = 1'b0;
        bus.Ctl_Branch_in = (v.aluop == 2'b01);
        bus.funct7_in = v.f7; bus.funct3_in = v.f3; bus.Rd_in = rd;
        bus.Immediate_in = v.imm; bus.ReadData1_in = v.a; bus.ReadData2_in = v.b;
        bus.PC_in = v.pc;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int rdy_low;
        logic [4:0] rd;
        rd = 5'(idx + 1);
        @(negedge clk);
        set_inputs(v, rd);
        bus.valid_in = 1'b1;
        chk($sformatf("v%0d ready before", idx), bus.ready_out, 1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        lat = 1; rdy_low = 0;
        while (bus.valid_out !== 1'b1 && lat < 60) begin
            if (bus.ready_out === 1'b0) begin
                // junk held on the bus while busy must not disturb the operation
                rdy_low++;
                bus.ReadData1_in = $urandom; bus.ReadData2_in = $urandom;
                bus.Immediate_in = $urandom; bus.funct3_in = 3'($urandom);
                bus.valid_in = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.valid_in = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, v.md ? 34 : 1);
        chk($sformatf("v%0d ready low cycles", idx), rdy_low, v.md ? 33 : 0);
        chk($sformatf("v%0d result", idx), bus.ALUresult_out, v.exp_res);
        chk($sformatf("v%0d zero", idx), bus.Zero_out, (v.exp_res == 0));
        chk($sformatf("v%0d branch taken", idx), bus.BranchTaken_out, v.exp_br);
        chk($sformatf("v%0d pcimm", idx), bus.PCimm_out, v.pc + v.imm);
        chk($sformatf("v%0d rd", idx), bus.Rd_out, rd);
        chk($sformatf("v%0d readdata2", idx), bus.ReadData2_out, v.b);
        chk($sformatf("v%0d regwrite", idx), bus.Ctl_RegWrite_out, 1);
        chk($sformatf("v%0d memtoreg", idx), bus.Ctl_MemtoReg_out, (v.aluop == 2'b00));
        chk($sformatf("v%0d ready with result", idx), bus.ready_out, 1);
        @(posedge clk); #1;
        chk($sformatf("v%0d bubble valid", idx), bus.valid_out, 0);
        chk($sformatf("v%0d bubble regwrite", idx),
            {bus.Ctl_RegWrite_out, bus.Ctl_Branch_out, bus.BranchTaken_out}, 0);
        chk($sformatf("v%0d bubble data hold", idx), bus.ALUresult_out, v.exp_res);
    endtask

    initial begin
        int pulses;
        // alusrc aluop f7 f3 a b imm pc exp br md
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b000, 3, 4, 0, 32'h100, 7, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h20, 3'b000, 13, 12, 0, 32'h100, 1, 0, 0));
        vecs.push_back(mk(1, 2'b11, 7'h00, 3'b000, 0, 32'hDEAD, 4, 32'h100, 4, 0, 0));
        vecs.push_back(mk(1, 2'b00, 7'h00, 3'b000, 0, 0, 6, 12, 6, 0, 0));
        vecs.push_back(mk(0, 2'b01, 7'h00, 3'b100, 32'hFFFFFFFB, 3, 32'h10, 32'h200,
                          32'hFFFFFFF8, 1, 0));
        vecs.push_back(mk(0, 2'b01, 7'h00, 3'b110, 32'hFFFFFFFB, 3, 32'h10, 32'h200,
                          32'hFFFFFFF8, 0, 0));
        vecs.push_back(mk(0, 2'b01, 7'h00, 3'b111, 32'hFFFFFFFB, 3, 32'h10, 32'h200,
                          32'hFFFFFFF8, 1, 0));
        vecs.push_back(mk(0, 2'b01, 7'h00, 3'b000, 7, 7, 32'h20, 32'h200, 0, 1, 0));
        vecs.push_back(mk(0, 2'b01, 7'h00, 3'b001, 7, 7, 32'h20, 32'h200, 0, 0, 0));
        vecs.push_back(mk(1, 2'b11, 7'h20, 3'b000, 5, 0, 32'h400, 32'h100, 32'h405, 0, 0));
        vecs.push_back(mk(1, 2'b11, 7'h20, 3'b101, 32'h80000000, 0, 32'h404, 32'h100,
                          32'hF8000000, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b101, 32'h80000000, 32'h24, 0, 32'h100,
                          32'h08000000, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b001, 1, 31, 0, 32'h100, 32'h80000000, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 1, 0, 32'h100, 1, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 1, 0, 32'h100, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b111, 32'hF0F0, 32'hFF00, 0, 32'h100, 32'hF000, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b110, 32'hF0F0, 32'hFF00, 0, 32'h100, 32'hFFF0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h00, 3'b100, 32'hF0F0, 32'hFF00, 0, 32'h100, 32'h0FF0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b000, 7, 6, 0, 32'h300, 42, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b000, 32'hFFFFFFFD, 5, 0, 32'h300, 32'hFFFFFFF1, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h300, 0, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h300,
                          32'hFFFFFFFE, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b010, 32'hFFFFFFFF, 2, 0, 32'h300, 32'hFFFFFFFF, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b100, 7, 0, 0, 32'h300, 32'hFFFFFFFF, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b110, 7, 0, 0, 32'h300, 7, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 32'h300,
                          32'h80000000, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 32'h300, 0, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b101, 20, 3, 0, 32'h300, 6, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b111, 20, 3, 0, 32'h300, 2, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b100, 32'hFFFFFFF9, 2, 0, 32'h300, 32'hFFFFFFFD, 0, 1));
        vecs.push_back(mk(0, 2'b10, 7'h01, 3'b110, 32'hFFFFFFF9, 2, 0, 32'h300, 32'hFFFFFFFF, 0, 1));

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", bus.valid_out, 0);
        chk("reset ctl", {bus.Ctl_MemtoReg_out, bus.Ctl_RegWrite_out, bus.Ctl_MemRead_out,
                          bus.Ctl_MemWrite_out, bus.Ctl_Branch_out, bus.Zero_out,
                          bus.BranchTaken_out}, 0);
        chk("reset data", {bus.ALUresult_out, bus.PCimm_out}, 0);
        chk("reset rd2/rd", {bus.ReadData2_out, bus.Rd_out}, 0);
        chk("reset ready", {bus.ready_out, bus.stall_out}, 2'b10);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // reset 10 cycles into a divide aborts it silently
        @(negedge clk);
        set_inputs(mk(0, 2'b10, 7'h01, 3'b100, 7, 3, 0, 32'h300, 2, 0, 1), 5'd9);
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk("abort busy", bus.ready_out, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort reset valid", bus.valid_out, 0);
        chk("abort reset data", {bus.ALUresult_out, bus.PCimm_out, bus.Rd_out}, 0);
        chk("abort reset regwrite", bus.Ctl_RegWrite_out, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready after reset", bus.ready_out, 1);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.valid_out === 1'b1) pulses++;
        end
        chk("abort no valid pulse", pulses, 0);
        run_vec(mk(0, 2'b10, 7'h00, 3'b000, 1, 1, 0, 32'h100, 2, 0, 0), 40);

        // M op with the multiplier/divider disabled
        @(negedge clk);
        bus_n.Ctl_ALUOpcode1_in = 1'b1; bus_n.Ctl_ALUOpcode0_in = 1'b0;
        bus_n.funct7_in = 7'h01; bus_n.funct3_in = 3'b000; bus_n.Ctl_RegWrite_in = 1'b1;
        bus_n.ReadData1_in = 7; bus_n.ReadData2_in = 6; bus_n.Rd_in = 5'd3;
        bus_n.valid_in = 1'b1;
        @(posedge clk); #1;
        bus_n.valid_in = 1'b0;
        chk("md off valid", bus_n.valid_out, 1);
        chk("md off result", bus_n.ALUresult_out, 0);
        chk("md off regwrite", bus_n.Ctl_RegWrite_out, 0);
        chk("md off ready", bus_n.ready_out, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
